// File: rtl/chime_arbiter.sv
// Priority arbiter sharing the piezo buzzer between the alarm, the hourly chime and the key click.
// Optional feature: define CHIME_ARB_REPLAY_EN to replay a chime that the alarm preempted.
module chime_arbiter #(
   parameter int unsigned CLICK_MS     = 20,
   parameter int unsigned CHIME_MS     = 200,
   parameter int unsigned ALARM_ON_MS  = 500,
   parameter int unsigned ALARM_OFF_MS = 500,
   parameter int unsigned ALARM_REPS   = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick_ms,
   input  logic       req_click,
   input  logic       req_chime,
   input  logic       alarm_active,
   input  logic       alarm_stop,
   input  logic       set_mode,
   output logic       buzz_en,
   output logic [1:0] tone_sel,
   output logic       busy,
   output logic       alarm_done
);

   typedef enum logic [2:0] {StIdle, StClick, StChime, StAlarmOn, StAlarmOff} state_e;

   localparam logic [15:0] ClickLast = 16'(CLICK_MS - 1);
   localparam logic [15:0] ChimeLast = 16'(CHIME_MS - 1);
   localparam logic [15:0] OnLast    = 16'(ALARM_ON_MS - 1);
   localparam logic [15:0] OffLast   = 16'(ALARM_OFF_MS - 1);
   localparam logic [7:0]  RepsLast  = 8'(ALARM_REPS - 1);

   state_e      state_q, state_d;
   logic        pend_click_q, pend_click_d;
   logic        pend_chime_q, pend_chime_d;
   logic        armed_q;
   logic [15:0] ms_cnt_q;
   logic [7:0]  rep_cnt_q;
   logic [15:0] dur_last;
   logic [1:0]  tone_d;
   logic        dur_done, alarm_elig, in_alarm, alarm_end, entering;

`ifdef CHIME_ARB_REPLAY_EN
   logic replay_q;

   // Remember a chime cut short by the alarm until the alarm sequence ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         replay_q <= 1'b0;
      end else if (state_q == StChime && state_d == StAlarmOn) begin
         replay_q <= 1'b1;
      end else if (alarm_end) begin
         replay_q <= 1'b0;
      end
   end
`endif

   always_comb begin
      dur_last = 16'd0;
      case (state_q)
         StClick:    dur_last = ClickLast;
         StChime:    dur_last = ChimeLast;
         StAlarmOn:  dur_last = OnLast;
         StAlarmOff: dur_last = OffLast;
         default:    dur_last = 16'd0;
      endcase
   end

   assign dur_done   = tick_ms && (ms_cnt_q == dur_last);
   assign alarm_elig = alarm_active && armed_q;
   assign in_alarm   = (state_q == StAlarmOn) || (state_q == StAlarmOff);

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (alarm_elig)        state_d = StAlarmOn;
            else if (pend_chime_q) state_d = StChime;
            else if (pend_click_q) state_d = StClick;
         end
         StClick, StChime: begin
            if (alarm_elig)    state_d = StAlarmOn;
            else if (dur_done) state_d = StIdle;
         end
         StAlarmOn: begin
            if (alarm_stop)    state_d = StIdle;
            else if (dur_done) state_d = StAlarmOff;
         end
         StAlarmOff: begin
            if (alarm_stop)    state_d = StIdle;
            else if (dur_done) state_d = (rep_cnt_q == RepsLast) ? StIdle : StAlarmOn;
         end
         default: state_d = StIdle;
      endcase
   end

   assign alarm_end = in_alarm && (state_d == StIdle);
   assign entering  = (state_d != state_q);

   // Entry clears a flag after any same-edge request, so a request that meets its own state is lost.
   always_comb begin
      pend_click_d = pend_click_q;
      pend_chime_d = pend_chime_q;
      if (req_click && state_q != StClick) pend_click_d = 1'b1;
      if (req_chime && !set_mode && state_q != StChime) pend_chime_d = 1'b1;
`ifdef CHIME_ARB_REPLAY_EN
      if (alarm_end && replay_q && !set_mode) pend_chime_d = 1'b1;
`endif
      if (entering && state_d == StClick) pend_click_d = 1'b0;
      if (entering && state_d == StChime) pend_chime_d = 1'b0;
   end

   always_comb begin
      tone_d = 2'd0;
      unique case (state_d)
         StClick:               tone_d = 2'd1;
         StChime:               tone_d = 2'd2;
         StAlarmOn, StAlarmOff: tone_d = 2'd3;
         default:               tone_d = 2'd0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         pend_click_q <= 1'b0;
         pend_chime_q <= 1'b0;
         armed_q      <= 1'b1;
         ms_cnt_q     <= 16'd0;
         rep_cnt_q    <= 8'd0;
         buzz_en      <= 1'b0;
         tone_sel     <= 2'd0;
         busy         <= 1'b0;
         alarm_done   <= 1'b0;
      end else begin
         state_q      <= state_d;
         pend_click_q <= pend_click_d;
         pend_chime_q <= pend_chime_d;

         if (alarm_end)          armed_q <= 1'b0;
         else if (!alarm_active) armed_q <= 1'b1;

         if (entering)                          ms_cnt_q <= 16'd0;
         else if (tick_ms && state_q != StIdle) ms_cnt_q <= ms_cnt_q + 16'd1;

         if (state_d != StAlarmOn && state_d != StAlarmOff) rep_cnt_q <= 8'd0;
         else if (state_q == StAlarmOff && dur_done)        rep_cnt_q <= rep_cnt_q + 8'd1;

         buzz_en    <= (state_d == StClick) || (state_d == StChime) || (state_d == StAlarmOn);
         tone_sel   <= tone_d;
         busy       <= (state_d != StIdle);
         alarm_done <= alarm_end;
      end
   end

endmodule

// File: doc/chime_arbiter.md
# chime_arbiter

Shares the single piezo buzzer between three sound requesters in the digital clock: the hourly chime pulse from the timekeeping counter, the alarm comparator's level request, and the key-click pulse from the key front end. A priority state machine grants the buzzer to one requester at a time. It times each sound pattern in milliseconds from a 1 ms strobe and drives the tone-select and enable inputs of the tone generator. All inputs are already synchronous to clk.

## Interface
- CLICK_MS, 20: click duration in ms ticks (1..65535)
- CHIME_MS, 200: chime duration in ms ticks (1..65535)
- ALARM_ON_MS, 500: alarm beep on-time in ms ticks (1..65535)
- ALARM_OFF_MS, 500: alarm beep off-time in ms ticks (1..65535)
- ALARM_REPS, 10: on/off repetitions before alarm self-terminates (1..255)

- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- tick_ms  in  1  one-cycle strobe every 1 ms
- req_click  in  1  one-cycle click request
- req_chime  in  1  one-cycle hourly chime request
- alarm_active  in  1  level; alarm time reached
- alarm_stop  in  1  one-cycle user acknowledge
- set_mode  in  1  clock in setting mode
- buzz_en  out  1  tone generator enable
- tone_sel  out  2  0 none, 1 click, 2 chime, 3 alarm
- busy  out  1  state != IDLE
- alarm_done  out  1  one-cycle pulse when an alarm sequence ends

## Operation
- States: IDLE, CLICK, CHIME, ALARM_ON, ALARM_OFF.
- Pending flags: pend_click and pend_chime.
  - Each is set on the edge where its request is sampled high.
  - Each is cleared on the edge its state is entered.
  - req_chime is ignored while set_mode = 1.
  - A request for the sound currently playing is discarded; it is not queued.
- Alarm eligibility: alarm_armed = 1 at reset. It clears when an alarm sequence ends and re-sets only after alarm_active is sampled low.
- Alarm eligible = alarm_active & alarm_armed.
- Priority: alarm > chime > click.
  - From IDLE, enter the highest-priority eligible source.
  - From CLICK or CHIME, an eligible alarm preempts immediately and enters ALARM_ON.
  - The preempted sound is dropped (see Configuration).
  - CHIME does not preempt CLICK. A chime arriving during a click stays pending.
- Duration counter:
  - ms_cnt is 16 bits. It resets to 0 on every state entry and increments on each tick_ms.
  - A state exits on the edge where tick_ms = 1 and ms_cnt = duration-1.
  - CLICK and CHIME exit to IDLE. ALARM_ON exits to ALARM_OFF. ALARM_OFF is described below.
- Alarm repetition:
  - rep_cnt is 8 bits. It increments on each ALARM_OFF exit.
  - After ALARM_REPS completed on/off pairs, go to IDLE and pulse alarm_done.
  - Otherwise re-enter ALARM_ON.
- alarm_stop in ALARM_ON or ALARM_OFF goes to IDLE on the next edge and pulses alarm_done. alarm_stop is ignored elsewhere.
- alarm_active falling mid-sequence does not stop the alarm; only alarm_stop or rep exhaustion does.
- Outputs:
  - buzz_en = 1 in CLICK, CHIME and ALARM_ON. buzz_en = 0 in ALARM_OFF and IDLE.
  - tone_sel encodes the current state; ALARM_OFF keeps tone_sel = 3.

## Timing
- Reset values: state IDLE, buzz_en 0, tone_sel 0, busy 0, alarm_done 0, pend_* 0, ms_cnt 0, rep_cnt 0, alarm_armed 1.
- Reset is asynchronous and may assert mid-sound. Outputs drop on assertion; pending requests are lost.
- Request latency:
  - A request sampled at edge E0 sets its pending flag after E0.
  - The state is entered at E1. buzz_en and tone_sel are registered with the state and are valid after E1.
- Alarm latency: alarm_active sampled high at E0 enters ALARM_ON at E0 itself. There is no pending stage for the alarm.
- Back-to-back sounds: IDLE is held for exactly 1 cycle between sounds.
- Simultaneous events on one edge:
  - alarm_stop together with a tick-driven exit: alarm_stop wins → IDLE.
  - A request together with its own state's exit: the request is discarded.
- Sound lengths: CLICK_MS ms ±1 tick_ms period, since the first tick may arrive anywhere in the first ms.

## Configuration
- CHIME_ARB_REPLAY_EN defined: a chime preempted by the alarm re-sets pend_chime. It plays in full after the alarm ends, provided set_mode = 0 at that time.
- CHIME_ARB_REPLAY_EN undefined: a preempted chime or click is dropped.
- Preempted clicks are never replayed in either build.

## Test plan
- Reset defaults, then req_click pulse → tone_sel = 1 and buzz_en high 2 cycles later, for exactly 20 tick_ms. Then IDLE and busy = 0.
- req_chime during CLICK → click completes, 1 IDLE cycle, then CHIME for 200 ticks. req_chime with set_mode = 1 → no sound.
- alarm_active held high with ALARM_REPS = 3 → on/off pattern 500/500 ×3, alarm_done pulse, IDLE. No re-trigger until alarm_active goes low then high.
- alarm_active rising at tick 100 of CHIME → ALARM_ON next edge. alarm_stop at tick 250 → IDLE plus alarm_done. Chime replays for 200 ticks only with CHIME_ARB_REPLAY_EN defined.
- Simultaneous req_click, req_chime and alarm_active → ALARM first. After alarm_stop, CHIME, then CLICK.
- rst_n asserted mid-ALARM_ON → buzz_en = 0 immediately. After release, IDLE with no pending sound.
